// File: rtl/clip_pkg.sv
// Shared clip rule for 16-bit samples.
// Contents:
//   CLIP_W    sample width
//   CLIP_NEG  value for negative overflow (zero-extended 0x80)
//   CLIP_POS  value for positive overflow (0x7F)
//   clip16()  returns {data, sat} for one sample, so every block applies the
//             identical rule.
package clip_pkg;

  localparam int              CLIP_W   = 16;
  localparam logic [CLIP_W-1:0] CLIP_NEG = 16'h0080;
  localparam logic [CLIP_W-1:0] CLIP_POS = 16'h007F;

  typedef struct packed {
    logic [CLIP_W-1:0] data;
    logic              sat;
  } clip_res_t;

  // Only bits [14:8] are inspected against the sign bit. In-range values,
  // including 0x0080..0x00FF and 0xFF00..0xFF7F, pass through untouched and
  // are not flagged.
  function automatic clip_res_t clip16(input logic signed [CLIP_W-1:0] x);
    clip_res_t r;
    r.data = x;
    r.sat  = 1'b0;
    if (x[15] && (x[14:8] != 7'h7F)) begin
      r.data = CLIP_NEG;
      r.sat  = 1'b1;
    end else if (!x[15] && (x[14:8] != 7'h00)) begin
      r.data = CLIP_POS;
      r.sat  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clip_share_arb_if.sv
// Requester and result handshake bundle for clip_share_arb.
// Signals:
//   req_valid[N_REQ]      requester i presents a sample
//   req_data[16*N_REQ]    sample i at [16*i +: 16]
//   req_ready[N_REQ]      sample i accepted this cycle (one-hot or zero)
//   out_valid/out_ready   result handshake
//   out_data, out_id, out_sat   clipped result, source index, saturation flag
// Modports:
//   slave   the arbiter/clip block
//   master  producers plus the downstream consumer
interface clip_share_arb_if
  import clip_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]        req_valid;
  logic [CLIP_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [CLIP_W-1:0]       out_data;
  logic [ID_W-1:0]         out_id;
  logic                    out_sat;
  logic                    out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_sat
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_sat
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request scanning from ptr
// upward, wrapping at N_REQ.
// Ports:
//   req        request vector
//   ptr        highest-priority index this cycle
//   enable     grant allowed this cycle
//   grant      one-hot grant (zero when no grant)
//   grant_idx  index of the winner (valid when any_grant)
//   any_grant  a grant is issued this cycle
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);

  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    // Modular scan also works when N_REQ is not a power of two.
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    any_grant = found && enable;
    grant     = any_grant ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/clip_share_arb.sv
// Shares one 16-bit saturate-to-byte clip datapath between N_REQ requesters.
// A round-robin arbiter grants at most one requester per cycle; the granted
// sample is clipped and registered into a single output stage with
// valid/ready, requester ID and saturation flag. sat_count tallies saturated
// results entering the output stage and sticks at all-ones.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   bus        clip_share_arb_if.slave (requesters and result handshake)
//   sat_clear  zeroes sat_count next cycle (wins over an increment)
//   sat_count  saturation event count
module clip_share_arb
  import clip_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  clip_share_arb_if.slave  bus,
  input  logic             sat_clear,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]   ptr;
  logic              can_accept;
  logic              arb_en;
  logic              any_grant;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic [CLIP_W-1:0] sel_p0;
  clip_res_t         res_p0;

  logic              vld_p1;
  logic [CLIP_W-1:0] data_p1;
  logic [ID_W-1:0]   id_p1;
  logic              sat_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
    return (g == LAST_ID) ? '0 : g + ID_W'(1);
  endfunction

  // Stage p0: arbitration and clip on the granted sample
  assign can_accept = !vld_p1 || bus.out_ready;
  // Gating on reset keeps req_ready low during the reset cycle, so no
  // requester believes it was accepted by a stage that is being cleared.
  assign arb_en     = can_accept && !reset;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.req_ready = grant;

  // One-hot AND-OR mux avoids a variable part-select on the packed bus.
  always_comb begin
    sel_p0 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_p0 = sel_p0 | bus.req_data[i*CLIP_W +: CLIP_W];
    end
  end

  assign res_p0 = clip16(sel_p0);

  // Stage p1: output register, pointer and saturation counter
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      id_p1     <= '0;
      sat_p1    <= 1'b0;
      ptr       <= '0;
      sat_count <= '0;
    end else begin
      if (any_grant) begin
        vld_p1  <= 1'b1;
        data_p1 <= res_p0.data;
        id_p1   <= grant_idx;
        sat_p1  <= res_p0.sat;
        ptr     <= next_ptr(grant_idx);
      end else if (bus.out_ready) begin
        vld_p1  <= 1'b0;
      end

      if (sat_clear) begin
        sat_count <= '0;
      end else if (any_grant && res_p0.sat) begin
        sat_count <= sat_inc(sat_count);
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_id    = id_p1;
  assign bus.out_sat   = sat_p1;

endmodule

// File: tb/tb_clip_share_arb.sv
module tb_clip_share_arb;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          sat_clear;
  logic [CW-1:0] sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  clip_share_arb_if #(.N_REQ(N), .ID_W(IDW)) bus ();

  clip_share_arb #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .sat_clear (sat_clear),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    bus.req_data[i*16 +: 16] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    sat_clear = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // Reference clip: in-range means the signed value fits in [-256, 255].
  function automatic void model_clip(input logic [15:0] x, output logic [15:0] r, output logic s);
    int v;
    v = int'($signed(x));
    if (v > 255) begin r = 16'h007F; s = 1'b1; end
    else if (v < -256) begin r = 16'h0080; s = 1'b1; end
    else begin r = x; s = 1'b0; end
  endfunction

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return 16'($urandom_range(16'h00F0, 16'h0110));
      2: return 16'($urandom_range(16'hFEF0, 16'hFF10));
      default: return 16'($urandom_range(0, 16'h00FF));
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sat_clear = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) set_data(i, 16'h0100 + 16'(i));
    #1;
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy got %b exp 0000", bus.req_ready); end
    cyc();
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy2 got %b exp 0000", bus.req_ready); end
    bus.req_valid = '0;
    rst = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h exp 0000", bus.out_data); end
    n_tests++; if (bus.out_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d exp 0", bus.out_id); end
    n_tests++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", bus.out_sat); end
    n_tests++; if (sat_count !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", sat_count); end
  endtask

  task automatic test_single();
    do_reset();
    set_data(0, 16'h0012);
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_rdy got %b exp 0001", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_vld got %b exp 1", bus.out_valid); end
    n_tests++; if (bus.out_data !== 16'h0012) begin n_fail++; $display("FAIL single_data got %h exp 0012", bus.out_data); end
    n_tests++; if (bus.out_id !== 2'd0) begin n_fail++; $display("FAIL single_id got %0d exp 0", bus.out_id); end
    n_tests++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL single_sat got %b exp 0", bus.out_sat); end
    n_tests++; if (sat_count !== 2'd0) begin n_fail++; $display("FAIL single_cnt got %0d exp 0", sat_count); end
  endtask

  task automatic test_clip();
    logic [15:0] din  [4] = '{16'h0100, 16'hFF80, 16'h8000, 16'hFFFF};
    logic [15:0] dexp [4] = '{16'h007F, 16'hFF80, 16'h0080, 16'hFFFF};
    logic        sexp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_data(0, din[k]);
      bus.req_valid = 4'b0001;
      cyc();
      n_tests++; if (bus.out_data !== dexp[k]) begin n_fail++; $display("FAIL clip_data[%0d] got %h exp %h", k, bus.out_data, dexp[k]); end
      n_tests++; if (bus.out_sat !== sexp[k]) begin n_fail++; $display("FAIL clip_sat[%0d] got %b exp %b", k, bus.out_sat, sexp[k]); end
    end
    n_tests++; if (sat_count !== 2'd2) begin n_fail++; $display("FAIL clip_cnt got %0d exp 2", sat_count); end
    bus.req_valid = '0;
    cyc();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clip_idle_vld got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 16'hFFFF) begin n_fail++; $display("FAIL clip_hold_data got %h exp ffff", bus.out_data); end
    sat_clear = 1'b1;
    cyc();
    sat_clear = 1'b0;
    n_tests++; if (sat_count !== 2'd0) begin n_fail++; $display("FAIL clip_clear got %0d exp 0", sat_count); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 16'h0010 + 16'(i));
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++; if (bus.req_ready !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL rr_rdy[%0d] got %b exp %b", k, bus.req_ready, 4'b0001 << (k % 4)); end
      cyc();
      n_tests++; if (bus.out_id !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, bus.out_id, k % 4); end
      n_tests++; if (bus.out_data !== 16'h0010 + 16'(k % 4)) begin n_fail++; $display("FAIL rr_data[%0d] got %h exp %h", k, bus.out_data, 16'h0010 + 16'(k % 4)); end
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_vld[%0d] got %b exp 1", k, bus.out_valid); end
    end
    bus.req_valid = '0;
    cyc();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(2, 16'h0005);
    set_data(3, 16'h0033);
    set_data(0, 16'h0044);
    set_data(1, 16'h0055);
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b1;
    cyc();
    n_tests++; if (bus.out_id !== 2'd2) begin n_fail++; $display("FAIL bp_id0 got %0d exp 2", bus.out_id); end
    n_tests++; if (bus.out_data !== 16'h0005) begin n_fail++; $display("FAIL bp_data0 got %h exp 0005", bus.out_data); end
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy[%0d] got %b exp 0000", k, bus.req_ready); end
      cyc();
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_vld[%0d] got %b exp 1", k, bus.out_valid); end
      n_tests++; if (bus.out_id !== 2'd2) begin n_fail++; $display("FAIL bp_id[%0d] got %0d exp 2", k, bus.out_id); end
      n_tests++; if (bus.out_data !== 16'h0005) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp 0005", k, bus.out_data); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_rdy got %b exp 1000", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    n_tests++; if (bus.out_id !== 2'd3) begin n_fail++; $display("FAIL bp_release_id got %0d exp 3", bus.out_id); end
    n_tests++; if (bus.out_data !== 16'h0033) begin n_fail++; $display("FAIL bp_release_data got %h exp 0033", bus.out_data); end
    cyc();
  endtask

  task automatic test_counter();
    int e;
    do_reset();
    set_data(0, 16'h7FFF);
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      e = (k > CMAX) ? CMAX : k;
      n_tests++; if (sat_count !== CW'(e)) begin n_fail++; $display("FAIL cnt_sat[%0d] got %0d exp %0d", k, sat_count, e); end
    end
    sat_clear = 1'b1;
    cyc();
    sat_clear = 1'b0;
    n_tests++; if (sat_count !== 2'd0) begin n_fail++; $display("FAIL cnt_clear_prio got %0d exp 0", sat_count); end
    n_tests++; if (bus.out_sat !== 1'b1) begin n_fail++; $display("FAIL cnt_clear_sat got %b exp 1", bus.out_sat); end
    cyc();
    n_tests++; if (sat_count !== 2'd1) begin n_fail++; $display("FAIL cnt_after_clear got %0d exp 1", sat_count); end
    bus.req_valid = '0;
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_data(1, 16'h7FFF);
    bus.req_valid = 4'b0010;
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) if (i != 1) set_data(i, 16'h0020 + 16'(i));
    cyc();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_held_vld got %b exp 1", bus.out_valid); end
    n_tests++; if (sat_count !== 2'd1) begin n_fail++; $display("FAIL rmid_cnt_pre got %0d exp 1", sat_count); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_rdy got %b exp 0000", bus.req_ready); end
    cyc();
    rst = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_vld got %b exp 0", bus.out_valid); end
    n_tests++; if (sat_count !== 2'd0) begin n_fail++; $display("FAIL rmid_cnt got %0d exp 0", sat_count); end
    n_tests++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_data got %h exp 0000", bus.out_data); end
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_next_rdy got %b exp 0001", bus.req_ready); end
    cyc();
    n_tests++; if (bus.out_id !== 2'd0) begin n_fail++; $display("FAIL rmid_next_id got %0d exp 0", bus.out_id); end
    n_tests++; if (bus.out_data !== 16'h0020) begin n_fail++; $display("FAIL rmid_next_data got %h exp 0020", bus.out_data); end
    bus.req_valid = '0;
    cyc();
  endtask

  task automatic test_random();
    logic [15:0] pend_d [N];
    bit          pend   [N];
    logic        m_vld, m_sat, s;
    logic [15:0] m_data, r;
    int          m_id, m_ptr, m_cnt, g, idx;
    logic [3:0]  exp_rdy;
    do_reset();
    m_vld = 1'b0; m_sat = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pend_d[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pend_d[i] = rand_sample();
        end
        bus.req_valid[i] = pend[i];
        set_data(i, pend_d[i]);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      sat_clear = ($urandom_range(0, 15) == 0);
      #1;
      g = -1;
      if (!m_vld || bus.out_ready) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && pend[idx]) g = idx;
        end
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy[%0d] got %b exp %b", c, bus.req_ready, exp_rdy); end
      s = 1'b0;
      if (g >= 0) begin
        model_clip(pend_d[g], r, s);
        m_data = r; m_sat = s; m_id = g; m_vld = 1'b1;
        m_ptr = (g + 1) % N;
        pend[g] = 1'b0;
      end else if (bus.out_ready) begin
        m_vld = 1'b0;
      end
      if (sat_clear) m_cnt = 0;
      else if (g >= 0 && s) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      cyc();
      n_tests++; if (bus.out_valid !== m_vld) begin n_fail++; $display("FAIL rnd_vld[%0d] got %b exp %b", c, bus.out_valid, m_vld); end
      n_tests++; if (bus.out_data !== m_data) begin n_fail++; $display("FAIL rnd_data[%0d] got %h exp %h", c, bus.out_data, m_data); end
      n_tests++; if (bus.out_id !== 2'(m_id)) begin n_fail++; $display("FAIL rnd_id[%0d] got %0d exp %0d", c, bus.out_id, m_id); end
      n_tests++; if (bus.out_sat !== m_sat) begin n_fail++; $display("FAIL rnd_sat[%0d] got %b exp %b", c, bus.out_sat, m_sat); end
      n_tests++; if (sat_count !== CW'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", c, sat_count, m_cnt); end
    end
    bus.req_valid = '0;
    sat_clear = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    sat_clear = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_clip();
    test_round_robin();
    test_backpressure();
    test_counter();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clip_share_arb.md
Name: clip_share_arb

Overview:
- Shares one 16-bit clip (saturate-to-byte) datapath between N_REQ requesters.
- Per-requester valid/ready inputs; a round-robin arbiter grants at most one requester per cycle.
- The granted sample is clipped and registered into a single output stage with valid/ready handshake, requester ID and saturation flag.
- A saturation event counter serves monitoring. Sits between the per-lane producers and the downstream consumer of clipped samples.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of out_id; must equal clog2(N_REQ).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  bit i: requester i presents a sample.
- req_data  in  16*N_REQ  sample of requester i at bits [16*i+15:16*i].
- req_ready  out  N_REQ  bit i: sample i accepted this cycle (one-hot or zero).
- out_valid  out  1  registered result valid.
- out_data  out  16  clipped result.
- out_id  out  ID_W  index of the requester that produced out_data.
- out_sat  out  1  result was saturated (positive or negative).
- out_ready  in  1  downstream accepts the result.
- sat_clear  in  1  clears sat_count.
- sat_count  out  CNT_W  number of saturated results accepted into the output stage; sticks at all-ones.

Behaviour:
- Clip function (exact, combinational on the granted sample x):
  - if x[15]=1 and x[14:8]!=7'h7F: result 16'h0080 (zero-extended), sat=1.
  - else if x[15]=0 and x[14:8]!=0: result 16'h007F, sat=1.
  - else: result x unchanged (16 bits, e.g. 16'hFFF0 passes as 16'hFFF0), sat=0.
- Stage free: can_accept = !out_valid || out_ready.
- Arbitration:
  - Round-robin pointer ptr (ID_W bits).
  - The granted requester is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N_REQ.
  - Grant occurs only when can_accept=1 and any req_valid=1.
  - req_ready[g]=1 for the granted index only. It is combinational from req_valid, ptr and out_valid/out_ready, and never asserts for an invalid requester.
- On grant:
  - out_data, out_sat and out_id load next edge; out_valid<=1; ptr<=(g+1) mod N_REQ.
  - Latency: one cycle from acceptance to out_valid.
- No grant and out_ready=1: out_valid<=0. Data registers hold their values.
- Backpressure: out_valid=1 and out_ready=0 means out_* hold stable and all req_ready=0. Full throughput of one result per cycle holds while out_ready=1.
- ptr does not move without a grant.
- Requesters must hold req_data stable while req_valid=1 and not yet accepted. The block does not check this.
- sat_count:
  - Increments on a grant whose clip result has sat=1.
  - Holds at 2^CNT_W-1 once it reaches that value.
  - sat_clear=1 forces 0 the next cycle and takes priority over a simultaneous increment.
- Reset (synchronous, priority over everything):
  - out_valid=0, out_data=0, out_id=0, out_sat=0, ptr=0, sat_count=0.
  - req_ready=0 during the reset cycle.
  - Reset mid-transfer discards the held result without a handshake.

Decomposition:
- Shared package clip_pkg:
  - constants CLIP_W=16, CLIP_NEG=16'h0080, CLIP_POS=16'h007F.
  - function clip16 returning result and sat flag, so other blocks reuse the identical rule.
- One sub-module rr_arbiter (N_REQ parameter): inputs req, ptr, enable; outputs one-hot grant, grant index and any_grant.
- Output register, pointer update and counter live in the top.

Test Plan:
- Single requester: req_valid=4'b0001, data 16'h0012, out_ready=1 -> next cycle out_valid=1, out_data=16'h0012, out_id=0, out_sat=0, sat_count=0.
- Clip values:
  - 16'h0100 -> 16'h007F, sat=1.
  - 16'hFF80 -> 16'hFF80, sat=0.
  - 16'h8000 -> 16'h0080, sat=1.
  - 16'hFFFF -> 16'hFFFF.
  - After the sequence, sat_count=2.
- Round robin: all four req_valid=1 continuously, out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles, one grant per cycle.
- Backpressure:
  - Grant requester 2 (out_id=2, out_data=16'h0005), then hold out_ready=0 for 3 cycles -> out_* stable, req_ready=0.
  - Raising out_ready grants the next requester (3 if valid) in the same cycle.
- Counter: drive 16'h7FFF with CNT_W=2 five times -> sat_count saturates at 3.
  - sat_clear together with a saturating grant -> sat_count=0.
- Reset mid-operation: assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, sat_count=0, ptr=0. The next grant with all req_valid=1 goes to requester 0.
